iir_mc: RTL
===========

# iir_mc

Multi-channel, parameterised fixed-point IIR filter for the FM radio datapath (de-emphasis and similar low-order filters). It pops one packed multi-channel sample word per input from an upstream FIFO and runs a direct-form I recursion per channel using shared coefficients. The recursion runs at the input rate; one result word is pushed to a downstream FIFO every DECIMATION inputs. Channels share one serial multiply-accumulate datapath.

## Interface
- CHANNELS, 2: independent channels packed into each word; channel c occupies bits [c*DATA_SIZE +: DATA_SIZE].
- TAPS, 2: number of feedforward taps; feedback uses taps 1..TAPS-1.
- DECIMATION, 1: one output per DECIMATION inputs; must be ≥1.
- DATA_SIZE, 32: signed sample and coefficient width.
- FRAC_BITS, 10: fractional bits of the coefficients; the dequantise shift amount.
- X_COEFFS, {0xB2, 0xB2}: feedforward coefficients b[0..TAPS-1].
- Y_COEFFS, {0x0, 0xFFFFFD66}: feedback coefficients a[0..TAPS-1]; a[0] is ignored.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- x_in  in  CHANNELS*DATA_SIZE  upstream FIFO head word; first-word fall-through, valid while x_empty=0.
- x_rd_en  out  1  pop strobe.
- x_empty  in  1  upstream FIFO empty.
- y_out  out  CHANNELS*DATA_SIZE  result word.
- y_out_full  in  1  downstream FIFO full.
- y_wr_en  out  1  push strobe.

## Operation
- States: READ, COMPUTE, WRITE.
- READ
  - If x_empty=0: x_rd_en=1 and x_in is shifted into each channel's x history (x[0] is newest). Go to COMPUTE.
  - Otherwise stay in READ.
- COMPUTE: runs for CHANNELS*TAPS cycles. Channel index is the outer loop and tap index k is the inner loop. Each cycle adds DQ(b[k]*x[k]) to the channel accumulator, plus DQ(a[k]*y[k-1]) for k≥1.
- DQ(p)
  - p is the full 2*DATA_SIZE signed product.
  - DQ(p) = -((-p)>>>FRAC_BITS) for p<0, otherwise p>>>FRAC_BITS. This rounds toward zero.
- Accumulator
  - Width is 2*DATA_SIZE+8; it is cleared at the start of each channel.
  - The final value is reduced to DATA_SIZE bits as described in Configuration.
- End of each channel's TAPS cycles
  - The result is shifted into that channel's y history and stored in that channel's y_out slot register.
  - Every input updates the y history, including decimated-away inputs.
- End of COMPUTE
  - If the decimation counter equals DECIMATION-1: reset the counter to 0 and go to WRITE.
  - Otherwise: increment the counter and go to READ.
- WRITE
  - If y_out_full=0: y_wr_en=1 for exactly that cycle, then go to READ.
  - Otherwise hold in WRITE with y_out stable.
- x_rd_en and y_wr_en are combinational decodes of the state and FIFO flags. They are never both high.

## Timing
- Reset (reset=0 at a clock edge)
  - State goes to READ; all x/y history, y_out, accumulators and the decimation counter go to 0.
  - x_rd_en=0 and y_wr_en=0 while reset is low.
  - Reset during COMPUTE or WRITE discards the in-flight sample and its result.
- Pop to push latency: if the pop happens in cycle T and the result is written, y_wr_en rises at cycle T+CHANNELS*TAPS+1 at the earliest. y_out is valid from that cycle.
- Throughput: one input per CHANNELS*TAPS+1 cycles, plus 1 cycle on each written input.
- Backpressure: y_out_full stalls only WRITE. No pops occur while in WRITE.
- x_empty is sampled only in READ.

## Configuration
- IIR_SATURATE_EN
  - Defined: the final accumulator value is clamped to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1] before it is stored to y history and y_out.
  - Undefined: the low DATA_SIZE bits are taken (two's-complement wrap). This matches per-term truncation arithmetic.

## Test plan
- Impulse test (defaults)
  - Stimulus: ch0 inputs 1024, 0, 0, 0; ch1 all 0.
  - Required: ch0 outputs 178, 63, -40, 26; ch1 outputs 0 every time.
- Decimation: DECIMATION=2 with the same stimulus -> exactly 2 pushes, ch0 values 63 then 26.
- Backpressure
  - Stimulus: hold y_out_full=1 for 5 cycles while in WRITE, then release.
  - Required: y_wr_en=0 and x_rd_en=0 throughout the stall with y_out unchanged; exactly one push in the release cycle.
- Empty FIFO: x_empty=1 for 10 cycles -> x_rd_en=0 and state stays READ; the first sample pops in the same cycle x_empty falls.
- Overflow test
  - Setup: X_COEFFS={0x800, 0x800}, Y_COEFFS=0; inputs 0x7FFFFFFF twice.
  - Required without the macro: outputs 0xFFFFFFFE, 0xFFFFFFFC.
  - Required with IIR_SATURATE_EN: outputs 0x7FFFFFFF, 0x7FFFFFFF.
- Reset mid-COMPUTE
  - Stimulus: assert reset mid-COMPUTE, then rerun the impulse test.
  - Required: no push from the aborted sample; outputs identical to the impulse test.

Source files
------------

// File: rtl/iir_mc.sv
// iir_mc: multi-channel direct-form I IIR filter with one serial MAC that is
// shared by every channel. It pops one packed sample word, runs the
// recursion channel by channel and tap by tap, and pushes a packed result
// word every DECIMATION inputs.
// Optional build macro: IIR_SATURATE_EN clamps each result to the signed
// DATA_SIZE range. Without it, results wrap to the low DATA_SIZE bits.
module iir_mc #(
  parameter int CHANNELS   = 2,
  parameter int TAPS       = 2,
  parameter int DECIMATION = 1,
  parameter int DATA_SIZE  = 32,
  parameter int FRAC_BITS  = 10,
  // Coefficient k occupies bits [k*DATA_SIZE +: DATA_SIZE]
  parameter logic [TAPS*DATA_SIZE-1:0] X_COEFFS = {32'h000000B2, 32'h000000B2},
  parameter logic [TAPS*DATA_SIZE-1:0] Y_COEFFS = {32'hFFFFFD66, 32'h00000000}
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [CHANNELS*DATA_SIZE-1:0] x_in,
  output logic                          x_rd_en,
  input  logic                          x_empty,
  output logic [CHANNELS*DATA_SIZE-1:0] y_out,
  input  logic                          y_out_full,
  output logic                          y_wr_en
);

  localparam int PROD_W = 2 * DATA_SIZE;
  localparam int ACC_W  = 2 * DATA_SIZE + 8;
  localparam int CH_W   = (CHANNELS > 1)   ? $clog2(CHANNELS)   : 1;
  localparam int TAP_W  = (TAPS > 1)       ? $clog2(TAPS)       : 1;
  localparam int DEC_W  = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  // Feedback needs outputs y[0..TAPS-2]; keep at least one entry
  localparam int YH_D   = (TAPS > 1) ? TAPS - 1 : 1;

`ifdef IIR_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    ST_READ,
    ST_COMPUTE,
    ST_WRITE
  } state_t;

  state_t state_q, state_d;

  logic [CH_W-1:0]  ch_q,  ch_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [DEC_W-1:0] dec_q, dec_d;

  logic signed [ACC_W-1:0] acc_q, acc_d;

  // x history: index 0 is the newest input of each channel
  logic signed [DATA_SIZE-1:0] x_hist_q [CHANNELS][TAPS];
  logic signed [DATA_SIZE-1:0] x_hist_d [CHANNELS][TAPS];
  // y history: index 0 is the most recent output of each channel
  logic signed [DATA_SIZE-1:0] y_hist_q [CHANNELS][YH_D];
  logic signed [DATA_SIZE-1:0] y_hist_d [CHANNELS][YH_D];
  // Per-channel output slots driving y_out
  logic [DATA_SIZE-1:0] y_slot_q [CHANNELS];
  logic [DATA_SIZE-1:0] y_slot_d [CHANNELS];

  logic signed [DATA_SIZE-1:0] b_sel, a_sel, x_sel, y_sel;
  logic signed [PROD_W-1:0]    prod_b, prod_a;
  logic signed [ACC_W-1:0]     term;
  logic                        use_fb;
  logic signed [DATA_SIZE-1:0] result;

  // Dequantise a full product, rounding toward zero
  function automatic logic signed [ACC_W-1:0] dq(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W:0] mag;
    logic signed [PROD_W:0] shf;
    mag = p[PROD_W-1] ? -((PROD_W+1)'(p)) : (PROD_W+1)'(p);
    shf = mag >>> FRAC_BITS;
    return p[PROD_W-1] ? -(ACC_W'(shf)) : ACC_W'(shf);
  endfunction

  // Select the coefficient/history operands for the current channel and tap
  always_comb begin
    b_sel  = '0;
    a_sel  = '0;
    x_sel  = '0;
    y_sel  = '0;
    use_fb = (tap_q != '0);
    for (int k = 0; k < TAPS; k++) begin
      if (tap_q == TAP_W'(k)) begin
        b_sel = X_COEFFS[k*DATA_SIZE +: DATA_SIZE];
        a_sel = Y_COEFFS[k*DATA_SIZE +: DATA_SIZE];
      end
    end
    for (int c = 0; c < CHANNELS; c++) begin
      for (int k = 0; k < TAPS; k++) begin
        if (ch_q == CH_W'(c) && tap_q == TAP_W'(k)) begin
          x_sel = x_hist_q[c][k];
        end
      end
      for (int k = 1; k < TAPS; k++) begin
        if (ch_q == CH_W'(c) && tap_q == TAP_W'(k)) begin
          y_sel = y_hist_q[c][k-1];
        end
      end
    end
    prod_b = PROD_W'(b_sel) * PROD_W'(x_sel);
    prod_a = PROD_W'(a_sel) * PROD_W'(y_sel);
    term   = dq(prod_b) + (use_fb ? dq(prod_a) : '0);
  end

  // Next-state, MAC sequencing, history updates and FIFO strobes
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    tap_d    = tap_q;
    dec_d    = dec_q;
    acc_d    = acc_q;
    x_hist_d = x_hist_q;
    y_hist_d = y_hist_q;
    y_slot_d = y_slot_q;
    x_rd_en  = 1'b0;
    y_wr_en  = 1'b0;
    result   = '0;

    case (state_q)
      ST_READ: begin
        if (!x_empty) begin
          x_rd_en = 1'b1;
          for (int c = 0; c < CHANNELS; c++) begin
            for (int k = TAPS - 1; k > 0; k--) begin
              x_hist_d[c][k] = x_hist_q[c][k-1];
            end
            x_hist_d[c][0] = x_in[c*DATA_SIZE +: DATA_SIZE];
          end
          ch_d    = '0;
          tap_d   = '0;
          state_d = ST_COMPUTE;
        end
      end

      ST_COMPUTE: begin
        // Tap 0 starts a fresh accumulation for the channel
        acc_d = ((tap_q == '0) ? '0 : acc_q) + term;
        if (tap_q == TAP_W'(TAPS - 1)) begin
`ifdef IIR_SATURATE_EN
          if (acc_d > SAT_MAX) begin
            result = SAT_MAX[DATA_SIZE-1:0];
          end else if (acc_d < SAT_MIN) begin
            result = SAT_MIN[DATA_SIZE-1:0];
          end else begin
            result = acc_d[DATA_SIZE-1:0];
          end
`else
          result = acc_d[DATA_SIZE-1:0];
`endif
          for (int c = 0; c < CHANNELS; c++) begin
            if (ch_q == CH_W'(c)) begin
              for (int k = YH_D - 1; k > 0; k--) begin
                y_hist_d[c][k] = y_hist_q[c][k-1];
              end
              y_hist_d[c][0] = result;
              y_slot_d[c]    = result;
            end
          end
          tap_d = '0;
          if (ch_q == CH_W'(CHANNELS - 1)) begin
            ch_d = '0;
            if (dec_q == DEC_W'(DECIMATION - 1)) begin
              dec_d   = '0;
              state_d = ST_WRITE;
            end else begin
              dec_d   = dec_q + DEC_W'(1);
              state_d = ST_READ;
            end
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end else begin
          tap_d = tap_q + TAP_W'(1);
        end
      end

      ST_WRITE: begin
        if (!y_out_full) begin
          y_wr_en = 1'b1;
          state_d = ST_READ;
        end
      end

      default: begin
        state_d = ST_READ;
      end
    endcase

    // Strobes stay low while reset is held, whatever the current state
    if (!reset) begin
      x_rd_en = 1'b0;
      y_wr_en = 1'b0;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_READ;
      ch_q    <= '0;
      tap_q   <= '0;
      dec_q   <= '0;
      acc_q   <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < TAPS; k++) begin
          x_hist_q[c][k] <= '0;
        end
        for (int k = 0; k < YH_D; k++) begin
          y_hist_q[c][k] <= '0;
        end
        y_slot_q[c] <= '0;
      end
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      tap_q    <= tap_d;
      dec_q    <= dec_d;
      acc_q    <= acc_d;
      x_hist_q <= x_hist_d;
      y_hist_q <= y_hist_d;
      y_slot_q <= y_slot_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_out
      assign y_out[gi*DATA_SIZE +: DATA_SIZE] = y_slot_q[gi];
    end
  endgenerate

endmodule
